pe_acc_buffer: RTL and testbench

- Per-PE accumulator buffer in the SCNN datapath.
- Takes partial products already routed by the crossbar, one lane per bank, and adds each into the bank entry named by its output-coordinate address.
- On a drain command it streams every bank's accumulated outputs to the post-processing unit (pooling/compress) in address order, clearing entries as they leave, so the buffer is ready for the next output-channel group.

---
 rtl/pe_acc_buffer_if.sv | 50 +++++
 rtl/pe_acc_buffer.sv | 199 +++++++++++++++++++
 tb/tb_pe_acc_buffer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_acc_buffer_if.sv
// Bus bundle between the crossbar/controller side and the PE accumulator
// buffer. The master modport is the producer of products and drain commands
// (crossbar + controller); the slave modport is the accumulator buffer itself.
//
// Signals:
//   xbar_valid                  per-lane product valid
//   xbar_addr                   per-lane entry address (lane i owns slice i)
//   xbar_data                   per-lane signed product
//   Conv_size_output_Boundary   number of entries per bank to drain
//   drain_Accumulator_buffer_en drain command (level)
//   buffer_PPU_valid/addr/data  drained word towards the post-processing unit
//   buffer_PPU_last             marks the final drained word
//   drain_done                  one-cycle pulse when a drain completes
//   busy                        high while draining
interface pe_acc_buffer_if #(
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ACC_W     = 24,
  parameter int unsigned AW        = $clog2(DEPTH)
) ();

  logic [NUM_BANKS-1:0]        xbar_valid;
  logic [NUM_BANKS*AW-1:0]     xbar_addr;
  logic [NUM_BANKS*DATA_W-1:0] xbar_data;
  logic [AW:0]                 Conv_size_output_Boundary;
  logic                        drain_Accumulator_buffer_en;

  logic                        buffer_PPU_valid;
  logic [AW-1:0]               buffer_PPU_addr;
  logic [NUM_BANKS*ACC_W-1:0]  buffer_PPU_data;
  logic                        buffer_PPU_last;
  logic                        drain_done;
  logic                        busy;

  modport master (
    output xbar_valid, xbar_addr, xbar_data,
    output Conv_size_output_Boundary, drain_Accumulator_buffer_en,
    input  buffer_PPU_valid, buffer_PPU_addr, buffer_PPU_data,
    input  buffer_PPU_last, drain_done, busy
  );

  modport slave (
    input  xbar_valid, xbar_addr, xbar_data,
    input  Conv_size_output_Boundary, drain_Accumulator_buffer_en,
    output buffer_PPU_valid, buffer_PPU_addr, buffer_PPU_data,
    output buffer_PPU_last, drain_done, busy
  );

endinterface

// File: rtl/pe_acc_buffer.sv
// Per-PE accumulator buffer of the SCNN datapath.
//
// Crossbar-routed partial products (one lane per bank) are added into the
// bank entry named by their output-coordinate address. A rising edge on the
// drain command streams entries 0..N-1 of all banks (N = min(boundary, DEPTH))
// to the post-processing unit, clearing each entry as it is read.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset; clears all entries and outputs
//   bus   pe_acc_buffer_if.slave: product lanes, drain command/boundary,
//         drained-word stream, drain_done pulse and busy flag
//
// Build option:
//   ACC_SATURATE_EN  when defined, the accumulate add saturates to the
//                    signed ACC_W range instead of wrapping.
module pe_acc_buffer #(
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ACC_W     = 24,
  parameter int unsigned AW        = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  pe_acc_buffer_if.slave bus
);

  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ACC_W-1:0] mem_q [NUM_BANKS][DEPTH];

  logic          drain_en_q;
  logic [CW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] n_q, n_d;

  logic                       valid_q, valid_d;
  logic [AW-1:0]              addr_q, addr_d;
  logic [NUM_BANKS*ACC_W-1:0] data_q, data_d;
  logic                       last_q, last_d;
  logic                       done_q, done_d;

  logic                       drain_start;
  logic [CW-1:0]              n_entry;
  logic                       clr_en;
  logic                       acc_en;
  logic [AW-1:0]              lane_addr [NUM_BANKS];
  logic [ACC_W-1:0]           acc_sum   [NUM_BANKS];
  logic [NUM_BANKS*ACC_W-1:0] drain_word;

  // Sign-extend the product and add it to the current entry value.
`ifdef ACC_SATURATE_EN
  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0]  a,
                                               input logic [DATA_W-1:0] p);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {{(ACC_W-DATA_W+1){p[DATA_W-1]}}, p};
    // Top two bits disagree only on signed overflow; clamp towards the sign.
    if (s[ACC_W] != s[ACC_W-1]) begin
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
    return s[ACC_W-1:0];
  endfunction
`else
  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0]  a,
                                               input logic [DATA_W-1:0] p);
    return a + {{(ACC_W-DATA_W){p[DATA_W-1]}}, p};
  endfunction
`endif

  assign drain_start = bus.drain_Accumulator_buffer_en && !drain_en_q;
  assign n_entry     = (bus.Conv_size_output_Boundary > CW'(DEPTH)) ?
                       CW'(DEPTH) : bus.Conv_size_output_Boundary;
  // Products sampled in the cycle the drain command rises are still taken,
  // because the FSM is still in ACCUM during that cycle.
  assign acc_en      = (state_q == ACCUM);
  assign clr_en      = (state_q == DRAIN) && (ptr_q < n_q);

  // The whole read-modify-write completes in one cycle against the entry
  // registers, so a back-to-back hit to the same address always sees the
  // previous sum without a separate forwarding path.
  always_comb begin
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      lane_addr[b] = bus.xbar_addr[b*AW +: AW];
      acc_sum[b]   = acc_add(mem_q[b][lane_addr[b]],
                             bus.xbar_data[b*DATA_W +: DATA_W]);
    end
  end

  always_comb begin
    drain_word = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      drain_word[b*ACC_W +: ACC_W] = mem_q[b][ptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        for (int unsigned e = 0; e < DEPTH; e++) begin
          mem_q[b][e] <= '0;
        end
      end
    end else begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        if (acc_en && bus.xbar_valid[b]) begin
          mem_q[b][lane_addr[b]] <= acc_sum[b];
        end
        if (clr_en) begin
          mem_q[b][ptr_q[AW-1:0]] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ACCUM;
      drain_en_q <= 1'b0;
      ptr_q      <= '0;
      n_q        <= '0;
      valid_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      drain_en_q <= bus.drain_Accumulator_buffer_en;
      ptr_q      <= ptr_d;
      n_q        <= n_d;
      valid_q    <= valid_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      last_q     <= last_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    n_d     = n_q;
    valid_d = 1'b0;
    addr_d  = '0;
    data_d  = '0;
    last_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ACCUM: begin
        if (drain_start) begin
          state_d = DRAIN;
          ptr_d   = '0;
          n_d     = n_entry;
        end
      end
      DRAIN: begin
        // The command level is ignored here: once started, a drain runs to
        // completion. done is registered alongside the final word; with N=0
        // it fires in the first DRAIN cycle and no word is issued.
        if (ptr_q < n_q) begin
          valid_d = 1'b1;
          addr_d  = ptr_q[AW-1:0];
          data_d  = drain_word;
          ptr_d   = ptr_q + 1'b1;
          if (ptr_q == n_q - 1'b1) begin
            last_d  = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end else begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!bus.drain_Accumulator_buffer_en) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  assign bus.buffer_PPU_valid = valid_q;
  assign bus.buffer_PPU_addr  = addr_q;
  assign bus.buffer_PPU_data  = data_q;
  assign bus.buffer_PPU_last  = last_q;
  assign bus.drain_done       = done_q;
  assign bus.busy             = (state_q == DRAIN);

endmodule

// File: tb/tb_pe_acc_buffer.sv
module tb_pe_acc_buffer;

  localparam int NB     = 4;
  localparam int DEPTH  = 64;
  localparam int DW     = 16;
  localparam int ACC_W  = 24;
  localparam int AW     = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pe_acc_buffer_if #(
    .NUM_BANKS(NB), .DEPTH(DEPTH), .DATA_W(DW), .ACC_W(ACC_W), .AW(AW)
  ) bus ();

  pe_acc_buffer #(
    .NUM_BANKS(NB), .DEPTH(DEPTH), .DATA_W(DW), .ACC_W(ACC_W), .AW(AW)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  typedef struct {
    logic [AW-1:0]       addr;
    logic [NB*ACC_W-1:0] data;
    logic                last;
  } word_t;

  word_t sb[$];

  int errors = 0;
  int checks = 0;
  int mdl [NB][DEPTH];
  bit pv [NB];
  int pa [NB];
  int pd [NB];
  bit accum_ok;
  int word_cnt = 0;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference accumulate: plain integer add, then wrap or clamp to 24 bits.
  function automatic int norm(input int s);
`ifdef ACC_SATURATE_EN
    if (s > 8388607)  return 8388607;
    if (s < -8388608) return -8388608;
    return s;
`else
    logic signed [23:0] t;
    t = s[23:0];
    return int'(t);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int l, input int a, input int d);
    pv[l] = 1'b1;
    pa[l] = a;
    pd[l] = d;
  endtask

  task automatic apply_lanes();
    for (int l = 0; l < NB; l++) begin
      bus.xbar_valid[l]          = pv[l];
      bus.xbar_addr[l*AW +: AW]  = AW'(pa[l]);
      bus.xbar_data[l*DW +: DW]  = DW'(pd[l]);
    end
  endtask

  task automatic clear_lanes();
    for (int l = 0; l < NB; l++) begin
      pv[l] = 1'b0;
      pa[l] = 0;
      pd[l] = 0;
    end
    apply_lanes();
  endtask

  task automatic commit_model();
    if (accum_ok) begin
      for (int l = 0; l < NB; l++) begin
        if (pv[l]) mdl[l][pa[l]] = norm(mdl[l][pa[l]] + pd[l]);
      end
    end
  endtask

  task automatic step();
    apply_lanes();
    commit_model();
    tick();
    clear_lanes();
  endtask

  task automatic random_products(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      for (int l = 0; l < NB; l++) begin
        if ($urandom_range(0, 1) == 1) put(l, $urandom_range(0, DEPTH-1),
                                          int'($urandom_range(0, 65535)) - 32768);
      end
      step();
    end
  endtask

  task automatic do_drain(input int bound, input bit drop_early,
                          input bit noise, input int abort_at);
    int    n;
    int    w0;
    bit    done_seen;
    word_t e;
    n = (bound > DEPTH) ? DEPTH : bound;
    bus.Conv_size_output_Boundary   = 7'(bound);
    bus.drain_Accumulator_buffer_en = 1'b1;
    apply_lanes();
    commit_model();
    for (int a = 0; a < n; a++) begin
      e.addr = AW'(a);
      e.data = '0;
      for (int b = 0; b < NB; b++) begin
        e.data[b*ACC_W +: ACC_W] = ACC_W'(mdl[b][a]);
        mdl[b][a] = 0;
      end
      e.last = (a == n - 1);
      sb.push_back(e);
    end
    accum_ok  = 1'b0;
    w0        = word_cnt;
    tick();
    clear_lanes();
    check("busy_in_drain", bus.busy, 1'b1);
    done_seen = 1'b0;
    for (int c = 0; c < n + 10; c++) begin
      if (noise && c < n) begin
        for (int l = 0; l < NB; l++)
          put(l, $urandom_range(0, DEPTH-1), $urandom_range(1, 1000));
        apply_lanes();
      end
      if (drop_early && c == 2) bus.drain_Accumulator_buffer_en = 1'b0;
      tick();
      clear_lanes();
      if (abort_at >= 0 && bus.buffer_PPU_valid &&
          bus.buffer_PPU_addr == AW'(abort_at)) begin
        rst_n = 1'b0;
        bus.drain_Accumulator_buffer_en = 1'b0;
        #1;
        check("rst_valid", bus.buffer_PPU_valid, 1'b0);
        check("rst_data",  bus.buffer_PPU_data, '0);
        check("rst_addr",  bus.buffer_PPU_addr, '0);
        check("rst_last",  bus.buffer_PPU_last, 1'b0);
        check("rst_done",  bus.drain_done, 1'b0);
        check("rst_busy",  bus.busy, 1'b0);
        sb.delete();
        for (int b = 0; b < NB; b++)
          for (int a = 0; a < DEPTH; a++) mdl[b][a] = 0;
        tick();
        rst_n = 1'b1;
        tick();
        check("busy_after_rst", bus.busy, 1'b0);
        accum_ok = 1'b1;
        return;
      end
      if (bus.drain_done) begin
        done_seen = 1'b1;
        check("done_with_last", bus.buffer_PPU_last, (n > 0));
        break;
      end
    end
    check("drain_done_seen", done_seen, 1'b1);
    tick();
    check("done_one_cycle", bus.drain_done, 1'b0);
    check("valid_after_done", bus.buffer_PPU_valid, 1'b0);
    check("sb_empty", sb.size(), 0);
    check("word_count", word_cnt - w0, n);
    repeat (2) tick();
    check("no_redrain_busy", bus.busy, 1'b0);
    bus.drain_Accumulator_buffer_en = 1'b0;
    tick();
    accum_ok = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.buffer_PPU_valid) begin
        word_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_word", 1'b1, 1'b0);
        end else begin
          word_t e;
          e = sb.pop_front();
          check("word_addr", bus.buffer_PPU_addr, e.addr);
          check("word_data", bus.buffer_PPU_data, e.data);
          check("word_last", bus.buffer_PPU_last, e.last);
        end
      end else if (bus.buffer_PPU_last) begin
        check("last_without_valid", bus.buffer_PPU_last, 1'b0);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.Conv_size_output_Boundary   = '0;
    bus.drain_Accumulator_buffer_en = 1'b0;
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < DEPTH; a++) mdl[b][a] = 0;
    clear_lanes();
    accum_ok = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", bus.buffer_PPU_valid, 1'b0);
    check("reset_data",  bus.buffer_PPU_data, '0);
    check("reset_addr",  bus.buffer_PPU_addr, '0);
    check("reset_last",  bus.buffer_PPU_last, 1'b0);
    check("reset_done",  bus.drain_done, 1'b0);
    check("reset_busy",  bus.busy, 1'b0);
    rst_n = 1'b1;
    tick();

    // Basic accumulate and drain: addr3 ends with bank0=3, bank1=7.
    put(0, 3, 5); put(1, 3, 7); step();
    put(0, 3, -2); step();
    do_drain(4, 1'b0, 1'b0, -1);

    // Same-address back-to-back, plus a product in the drain-edge cycle.
    for (int i = 0; i < 8; i++) begin
      put(2, 10, 1); step();
    end
    put(0, 1, 9);
    do_drain(16, 1'b0, 1'b0, -1);

    // Clear-on-drain: second drain must return zeros.
    put(0, 3, 5); put(1, 3, 7); step();
    put(0, 3, -2); step();
    do_drain(4, 1'b0, 1'b0, -1);
    do_drain(4, 1'b0, 1'b0, -1);

    // Entries at or above N survive a drain.
    put(1, 20, 123); put(3, 0, 44); step();
    do_drain(8, 1'b0, 1'b0, -1);
    do_drain(0, 1'b0, 1'b0, -1);
    do_drain(32, 1'b0, 1'b0, -1);

    // Boundary above DEPTH, command dropped mid-drain, products during drain.
    random_products(40);
    do_drain(100, 1'b1, 1'b1, -1);
    do_drain(64, 1'b0, 1'b0, -1);

    // Overflow on a single entry.
    for (int i = 0; i < 300; i++) begin
      put(3, 5, 32767); step();
    end
    do_drain(8, 1'b0, 1'b0, -1);

    // Reset at word 2 of a 16-word drain, then drain must be all zeros.
    random_products(12);
    do_drain(16, 1'b0, 1'b0, 2);
    do_drain(16, 1'b0, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
